// File: rtl/montexp_pkg.sv
// Shared types and defaults for the modular-exponentiation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package montexp_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int EXP_W_DEF  = 512;
    localparam int CNT_W_DEF  = $clog2(EXP_W_DEF);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SQ   = 3'd2,
        ST_MUL  = 3'd3,
        ST_POST = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // Bit-counter width for an arbitrary exponent width; a 1-bit exponent
    // still needs a 1-bit counter.
    function automatic int cnt_w(input int exp_w);
        return (exp_w > 1) ? $clog2(exp_w) : 1;
    endfunction

endpackage

// File: rtl/montgomery_exp_ctrl_if.sv
// Link between the exponentiation controller and one Montgomery multiplier.
// Latency: n/a (wires only).
// Backpressure: start/done handshake; operands held from mont_start until mont_done is taken.
//
// master: controller side (drives mont_start, mont_a, mont_b, mont_m).
// slave : multiplier side (drives mont_result, mont_done).
interface montgomery_exp_ctrl_if
    import montexp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              mont_start;
    logic [DATA_W-1:0] mont_a;
    logic [DATA_W-1:0] mont_b;
    logic [DATA_W-1:0] mont_m;
    logic [DATA_W-1:0] mont_result;
    logic              mont_done;

    modport master (
        output mont_start, mont_a, mont_b, mont_m,
        input  mont_result, mont_done
    );

    modport slave (
        input  mont_start, mont_a, mont_b, mont_m,
        output mont_result, mont_done
    );

endinterface

// File: rtl/montexp_bitscan.sv
// Exponent scanner: MSB-first shift register, remaining-bit counter and last-bit flag.
// Latency: cur_bit/last_bit valid the cycle after load, advance one bit per shift.
// Backpressure: none; advances only when shift is asserted.
//
// Ports: clk, resetn; load/load_e capture a new exponent; shift moves to the
// next lower bit; cur_bit is the bit under scan, last_bit flags exponent bit 0.
module montexp_bitscan
    import montexp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [EXP_W-1:0] load_e,
    input  logic             shift,
    output logic             cur_bit,
    output logic             last_bit
);

    localparam int CNT_W = cnt_w(EXP_W);

    logic [EXP_W-1:0] sh_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sh_q  <= load_e;
            cnt_q <= CNT_W'(EXP_W - 1);
        end else if (shift) begin
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cur_bit  = sh_q[EXP_W-1];
    // Counter holds the index of the bit under scan, so zero means bit 0.
    assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right modular exponentiation x^e mod M sequencing one Montgomery multiplier.
// Latency: 2 + EXP_W + popcount(e) multiplies (2 + 2*EXP_W with MONTEXP_CONST_TIME_EN) plus a few cycles.
// Backpressure: start is ignored while busy; each multiply waits for mont_done.
//
// Ports: clk, resetn (async, active low); start with in_x/in_e/in_m/in_rmodm/in_r2modm
// captured on acceptance; result/busy/done towards the host; mont (master) to the multiplier.
// Optional build macro MONTEXP_CONST_TIME_EN: the multiply step runs for every exponent
// bit and its product is discarded for zero bits, so timing does not depend on e.
module montgomery_exp_ctrl
    import montexp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [DATA_W-1:0]    in_x,
    input  logic [EXP_W-1:0]     in_e,
    input  logic [DATA_W-1:0]    in_m,
    input  logic [DATA_W-1:0]    in_rmodm,
    input  logic [DATA_W-1:0]    in_r2modm,
    output logic [DATA_W-1:0]    result,
    output logic                 busy,
    output logic                 done,
    montgomery_exp_ctrl_if.master mont
);

    state_t state_q, state_d;

    logic [DATA_W-1:0] x_q, m_q, rmodm_q, r2_q, xt_q, a_q, result_q;
    logic              wait_q;    // multiply issued, waiting for its done
    logic              armed_q;   // mont_done has been low since issue
    logic              mm_state, mm_issue, mm_take;
    logic              cur_bit, last_bit, scan_load, scan_shift, mul_needed;

    assign mm_state  = (state_q == ST_PRE) || (state_q == ST_SQ) ||
                       (state_q == ST_MUL) || (state_q == ST_POST);
    assign mm_issue  = mm_state && !wait_q;
    // A done level left over from the previous multiply must drop before
    // it can complete the current one; a fresh done is taken on first sight.
    assign mm_take   = mm_state && wait_q && armed_q && mont.mont_done;
    assign scan_load = (state_q == ST_IDLE) && start;

`ifdef MONTEXP_CONST_TIME_EN
    assign mul_needed = 1'b1;
`else
    assign mul_needed = cur_bit;
`endif

    montexp_bitscan #(
        .EXP_W (EXP_W)
    ) u_bitscan (
        .clk      (clk),
        .resetn   (resetn),
        .load     (scan_load),
        .load_e   (in_e),
        .shift    (scan_shift),
        .cur_bit  (cur_bit),
        .last_bit (last_bit)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)   state_d = ST_PRE;
            ST_PRE:  if (mm_take) state_d = ST_SQ;
            ST_SQ:   if (mm_take) state_d = mul_needed ? ST_MUL :
                                            (last_bit ? ST_POST : ST_SQ);
            ST_MUL:  if (mm_take) state_d = last_bit ? ST_POST : ST_SQ;
            ST_POST: if (mm_take) state_d = ST_FIN;
            ST_FIN:               state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Outputs: operand steering, handshake and scan control
    always_comb begin
        mont.mont_start = mm_issue;
        mont.mont_a     = '0;
        mont.mont_b     = '0;
        mont.mont_m     = m_q;
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_FIN);
        scan_shift      = 1'b0;
        case (state_q)
            ST_PRE: begin
                mont.mont_a = x_q;
                mont.mont_b = r2_q;
            end
            ST_SQ: begin
                mont.mont_a = a_q;
                mont.mont_b = a_q;
                scan_shift  = mm_take && !mul_needed && !last_bit;
            end
            ST_MUL: begin
                mont.mont_a = a_q;
                mont.mont_b = xt_q;
                scan_shift  = mm_take && !last_bit;
            end
            ST_POST: begin
                mont.mont_a = a_q;
                mont.mont_b = DATA_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath and multiply handshake tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q      <= '0;
            m_q      <= '0;
            rmodm_q  <= '0;
            r2_q     <= '0;
            xt_q     <= '0;
            a_q      <= '0;
            result_q <= '0;
            wait_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            if (scan_load) begin
                x_q     <= in_x;
                m_q     <= in_m;
                rmodm_q <= in_rmodm;
                r2_q    <= in_r2modm;
            end

            if (mm_issue) begin
                wait_q  <= 1'b1;
                armed_q <= !mont.mont_done;
            end else if (mm_take) begin
                wait_q  <= 1'b0;
            end else if (wait_q && !mont.mont_done) begin
                armed_q <= 1'b1;
            end

            if (mm_take) begin
                case (state_q)
                    ST_PRE: begin
                        xt_q <= mont.mont_result;
                        a_q  <= rmodm_q;          // Montgomery form of 1
                    end
                    ST_SQ:  a_q <= mont.mont_result;
                    // Product is kept only for a set bit (always true
                    // unless every bit runs the multiply step).
                    ST_MUL: if (cur_bit) a_q <= mont.mont_result;
                    ST_POST: begin
                        a_q      <= mont.mont_result;
                        result_q <= mont.mont_result;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
module tb_montgomery_exp_ctrl;

    localparam int DATA_W = 512;
    localparam int EXP_W  = 8;

`ifdef MONTEXP_CONST_TIME_EN
    localparam int OPS_05 = 18, OPS_00 = 18, OPS_01 = 18, OPS_FF = 18;
`else
    localparam int OPS_05 = 12, OPS_00 = 10, OPS_01 = 11, OPS_FF = 18;
`endif

    logic              clk, resetn, start, busy, done;
    logic [DATA_W-1:0] in_x, in_m, in_rmodm, in_r2modm, result;
    logic [EXP_W-1:0]  in_e;

    montgomery_exp_ctrl_if #(.DATA_W(DATA_W)) mif ();

    montgomery_exp_ctrl #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x      (in_x),
        .in_e      (in_e),
        .in_m      (in_m),
        .in_rmodm  (in_rmodm),
        .in_r2modm (in_r2modm),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .mont      (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int core_lat = 5;     // 0 selects a random latency in 3..10
    int core_hold = 1;    // cycles mont_done stays high
    int mm_total = 0;     // mont_start pulses seen by the multiplier model
    int done_count = 0;
    int last_ops = 0;
    int last_lat = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic longint rmod(input longint m);
        longint r = 1;
        for (int i = 0; i < DATA_W; i++) r = (r * 2) % m;
        return r;
    endfunction

    function automatic longint powmod(input longint x, input longint e, input longint m);
        longint r = 1 % m;
        for (longint i = 0; i < e; i++) r = (r * x) % m;
        return r;
    endfunction

    function automatic int exp_ops(input logic [EXP_W-1:0] e);
`ifdef MONTEXP_CONST_TIME_EN
        return 2 + 2 * EXP_W;
`else
        return 2 + EXP_W + $countones(e);
`endif
    endfunction

    // Bit-serial a*b*2^-DATA_W mod m
    function automatic logic [DATA_W-1:0] mm(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] m);
        logic [DATA_W+1:0] t;
        t = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[DATA_W-1:0];
    endfunction

    // Montgomery multiplier model, sampling and driving on the falling edge
    task automatic core_loop();
        bit pending = 0, prev_start = 0, stab_bad = 0;
        int cnt = 0, hold = 0;
        logic [DATA_W-1:0] res, ra, rb, rm;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pending = 0; hold = 0; prev_start = 0;
                mif.mont_done = 1'b0;
                continue;
            end
            if (pending && (mif.mont_a !== ra || mif.mont_b !== rb || mif.mont_m !== rm))
                stab_bad = 1;
            if (hold > 0) begin
                hold--;
                if (hold == 0) mif.mont_done = 1'b0;
            end
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending = 0;
                    mif.mont_result = res;
                    mif.mont_done = 1'b1;
                    hold = core_hold;
                    tests++;
                    if (stab_bad) begin
                        fails++;
                        $display("FAIL operand_hold: operands changed while multiply outstanding");
                    end
                end
            end
            if (mif.mont_start) begin
                tests++;
                if (pending || prev_start) begin
                    fails++;
                    $display("FAIL mont_start_issue: pending=%0b prev_start=%0b, want 0 0", pending, prev_start);
                end
                ra = mif.mont_a; rb = mif.mont_b; rm = mif.mont_m;
                res = mm(ra, rb, rm);
                cnt = (core_lat == 0) ? int'($urandom_range(10, 3)) : core_lat;
                pending = 1; stab_bad = 0;
                mm_total++;
            end
            prev_start = mif.mont_start;
        end
    endtask

    // Host-side model: on acceptance, the run must end in one done pulse with
    // x^e mod M and the predicted number of multiplies; busy tracks the run.
    task automatic compare_loop();
        logic [DATA_W-1:0] m_res;
        int m_ops = 0, m_base = 0, m_cycles = 0;
        bit m_active = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_active = 0;
                continue;
            end
            if (m_active) m_cycles++;
            tests++;
            if (busy !== m_active) begin
                fails++;
                $display("FAIL busy: got %0b, want %0b", busy, m_active);
            end
            if (done) begin
                tests++;
                if (!m_active) begin
                    fails++;
                    $display("FAIL done_stray: got done=1, want 0 (no run active)");
                end else begin
                    chk("model_result", result, m_res);
                    chk("model_ops", DATA_W'(mm_total - m_base), DATA_W'(m_ops));
                    last_ops = mm_total - m_base;
                    last_lat = m_cycles;
                end
                m_active = 0;
                done_count++;
            end else if (!m_active && start) begin
                m_res    = DATA_W'(powmod(longint'(in_x[31:0]), longint'(in_e), longint'(in_m[31:0])));
                m_ops    = exp_ops(in_e);
                m_base   = mm_total;
                m_cycles = 0;
                m_active = 1;
            end
        end
    endtask

    task automatic run_exp(input string tag, input int x, input logic [EXP_W-1:0] e,
                           input int m, input int lat, input int hold, input bit poke,
                           input bit chg_x, input bit rel, input longint want,
                           input int want_ops);
        int d0;
        longint r;
        core_lat  = lat;
        core_hold = hold;
        r = rmod(m);
        @(posedge clk); #1;
        if (rel) resetn = 1'b1;
        in_x = DATA_W'(x); in_e = e; in_m = DATA_W'(m);
        in_rmodm = DATA_W'(r); in_r2modm = DATA_W'((r * r) % m);
        start = 1'b1;
        d0 = done_count;
        @(posedge clk); #1;
        start = 1'b0;
        if (chg_x) in_x = DATA_W'(4);
        for (int i = 0; i < 4000 && done_count == d0; i++) begin
            @(posedge clk); #1;
            start = poke && (i == 20);
        end
        start = 1'b0;
        if (done_count == d0) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no done within 4000 cycles", tag);
        end else begin
            repeat (3) @(posedge clk);
            #1;
            chk({tag, "_result"}, result, DATA_W'(want));
            chk({tag, "_ops"}, DATA_W'(last_ops), DATA_W'(want_ops));
            chk({tag, "_done_pulses"}, DATA_W'(done_count - d0), DATA_W'(1));
        end
    endtask

    initial begin
        int lat_e00, lat_eff, d0, b0;
        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_e = '0; in_m = '0; in_rmodm = '0; in_r2modm = '0;
        mif.mont_done = 1'b0; mif.mont_result = '0;
        fork
            compare_loop();
            core_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", DATA_W'(busy), '0);
        chk("rst_done", DATA_W'(done), '0);
        chk("rst_mont_start", DATA_W'(mif.mont_start), '0);
        chk("rst_result", result, '0);

        // Start is accepted on the first edge after release
        run_exp("x3e05", 3, 8'h05, 7, 0, 1, 0, 0, 1, 5, OPS_05);
        run_exp("x5e00", 5, 8'h00, 11, 0, 1, 0, 0, 0, 1, OPS_00);
        run_exp("x5e01", 5, 8'h01, 11, 0, 1, 0, 0, 0, 5, OPS_01);

        run_exp("x2e00", 2, 8'h00, 13, 5, 1, 0, 0, 0, 1, OPS_00);
        lat_e00 = last_lat;
        run_exp("x2eff", 2, 8'hFF, 13, 5, 1, 0, 0, 0, 8, OPS_FF);
        lat_eff = last_lat;
`ifdef MONTEXP_CONST_TIME_EN
        chk("const_time_latency", DATA_W'(lat_eff), DATA_W'(lat_e00));
`else
        chk("latency_grows_with_popcount", DATA_W'(lat_eff > lat_e00), DATA_W'(1));
`endif

        // Sticky mont_done plus a start pulse mid-run
        run_exp("hold3_poke", 3, 8'h05, 7, 0, 3, 1, 0, 0, 5, OPS_05);
        repeat (10) @(posedge clk);
        #1;
        chk("result_held", result, DATA_W'(5));

        // Base input changes right after acceptance
        run_exp("x_change", 3, 8'h05, 7, 0, 1, 0, 1, 0, 5, OPS_05);

        // Reset in the middle of the 4th multiply
        core_lat = 5; core_hold = 1;
        @(posedge clk); #1;
        in_x = DATA_W'(3); in_e = 8'h05; in_m = DATA_W'(7);
        in_rmodm = DATA_W'(rmod(7)); in_r2modm = DATA_W'((rmod(7) * rmod(7)) % 7);
        start = 1'b1;
        d0 = done_count; b0 = mm_total;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2000 && mm_total < b0 + 4; i++) @(negedge clk);
        chk("reset_reached_op4", DATA_W'(mm_total - b0), DATA_W'(4));
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_mont_start", DATA_W'(mif.mont_start), '0);
        chk("mid_rst_busy", DATA_W'(busy), '0);
        chk("mid_rst_done", DATA_W'(done), '0);
        chk("mid_rst_result", result, '0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_done", DATA_W'(done_count - d0), '0);
        run_exp("after_rst", 3, 8'h05, 7, 0, 1, 0, 0, 1, 5, OPS_05);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
